// File: rtl/ddr_maint_pkg.sv
// Shared defaults, types and helpers for the DDR maintenance (refresh) logic.
package ddr_maint_pkg;

  localparam int unsigned DEF_NUM_RANKS     = 2;
  localparam int unsigned DEF_TREFI_CYCLES  = 640000;
  localparam int unsigned DEF_MAX_OWED      = 8;
  localparam int unsigned DEF_URGENT_THRESH = 6;

  // Index width that stays at least one bit wide for a single-entry range.
  function automatic int unsigned rank_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_RANK_W = rank_width(DEF_NUM_RANKS);
  localparam int unsigned DEF_OWED_W = $clog2(DEF_MAX_OWED + 1);

  typedef logic [DEF_RANK_W-1:0] rank_id_t;
  typedef logic [DEF_OWED_W-1:0] owed_cnt_t;

  typedef enum logic {
    ST_ARB = 1'b0,
    ST_REQ = 1'b1
  } req_state_t;

endpackage

// File: rtl/refresh_rank_tracker.sv
// Per-rank refresh bookkeeping: tREFI interval, owed credit count, urgency and sticky overflow.
module refresh_rank_tracker
  import ddr_maint_pkg::*;
#(
  parameter int unsigned TREFI_CYCLES  = DEF_TREFI_CYCLES,
  parameter int unsigned MAX_OWED      = DEF_MAX_OWED,
  parameter int unsigned URGENT_THRESH = DEF_URGENT_THRESH
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               ref_en,
  input  logic                               dec,
  output logic [$clog2(MAX_OWED+1)-1:0]      owed,
  output logic                               urgent,
  output logic                               urgent_next_c,
  output logic                               overflow
);

  localparam int unsigned CNT_W  = rank_width(TREFI_CYCLES);
  localparam int unsigned OWED_W = $clog2(MAX_OWED + 1);

  logic              expiry_c;
  logic [OWED_W-1:0] owed_next;
  logic              ovf_set;

  single_edge_counter #(
    .SIZE    (CNT_W),
    .MAX_VAL (TREFI_CYCLES - 1)
  ) u_interval (
    .clk    (clk),
    .n_rst  (n_rst),
    .en     (ref_en),
    .wrap_c (expiry_c)
  );

  // An expiry and a grant in the same cycle cancel; expiry at the limit saturates.
  always_comb begin
    owed_next = owed;
    ovf_set   = 1'b0;
    if (expiry_c && !dec) begin
      if (owed == OWED_W'(MAX_OWED)) begin
        ovf_set = 1'b1;
      end else begin
        owed_next = owed + OWED_W'(1);
      end
    end else if (dec && !expiry_c) begin
      owed_next = owed - OWED_W'(1);
    end
  end

  assign urgent_next_c = (owed_next >= OWED_W'(URGENT_THRESH));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      owed     <= '0;
      urgent   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      owed     <= owed_next;
      urgent   <= urgent_next_c;
      overflow <= overflow | ovf_set;
    end
  end

endmodule

// File: rtl/single_edge_counter.sv
// Free-running modulo counter: counts 0..MAX_VAL while enabled, flags the wrap cycle.
module single_edge_counter #(
  parameter int unsigned SIZE    = 4,
  parameter int unsigned MAX_VAL = 15
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  output logic wrap_c
);

  logic [SIZE-1:0] count;

  assign wrap_c = en && (count == SIZE'(MAX_VAL));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap_c ? '0 : count + SIZE'(1);
    end
  end

endmodule

// File: rtl/refresh_scheduler.sv
// Multi-rank refresh generator: per-rank trackers feed a round-robin, urgency-first arbiter
// whose winner is held as a registered request until the command scheduler issues it.
module refresh_scheduler
  import ddr_maint_pkg::*;
#(
  parameter int unsigned NUM_RANKS     = DEF_NUM_RANKS,
  parameter int unsigned TREFI_CYCLES  = DEF_TREFI_CYCLES,
  parameter int unsigned MAX_OWED      = DEF_MAX_OWED,
  parameter int unsigned URGENT_THRESH = DEF_URGENT_THRESH
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               ref_en,
  input  logic                               cmd_issued,
  output logic                               ref_req,
  output logic [rank_width(NUM_RANKS)-1:0]   ref_rank,
  output logic                               ref_urgent,
  output logic [NUM_RANKS-1:0]               owed_overflow
);

  localparam int unsigned RANK_W = rank_width(NUM_RANKS);
  localparam int unsigned OWED_W = $clog2(MAX_OWED + 1);

  req_state_t        state;
  req_state_t        state_next;
  logic [RANK_W-1:0] ptr;
  logic [RANK_W-1:0] ptr_next;
  logic [RANK_W-1:0] rank_next;
  logic              urgent_next;

  logic [OWED_W-1:0]    owed [NUM_RANKS];
  logic [NUM_RANKS-1:0] has_owed;
  logic [NUM_RANKS-1:0] urgent;
  logic [NUM_RANKS-1:0] urgent_nxt;
  logic [NUM_RANKS-1:0] dec;
  logic                 handshake;

  logic              any_cand;
  logic              urg_found;
  logic [RANK_W-1:0] any_win;
  logic [RANK_W-1:0] urg_win;
  logic [RANK_W-1:0] winner;
  int unsigned       idx;

  assign ref_req   = (state == ST_REQ);
  assign handshake = ref_req && cmd_issued;

  for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
    assign dec[r]      = handshake && (ref_rank == RANK_W'(r));
    assign has_owed[r] = (owed[r] != '0);

    refresh_rank_tracker #(
      .TREFI_CYCLES  (TREFI_CYCLES),
      .MAX_OWED      (MAX_OWED),
      .URGENT_THRESH (URGENT_THRESH)
    ) u_tracker (
      .clk           (clk),
      .n_rst         (n_rst),
      .ref_en        (ref_en),
      .dec           (dec[r]),
      .owed          (owed[r]),
      .urgent        (urgent[r]),
      .urgent_next_c (urgent_nxt[r]),
      .overflow      (owed_overflow[r])
    );
  end

  // Scan ranks in rotation order from ptr; the first urgent candidate beats the first plain one.
  always_comb begin
    any_cand  = 1'b0;
    urg_found = 1'b0;
    any_win   = '0;
    urg_win   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_RANKS; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_RANKS) begin
        idx = idx - NUM_RANKS;
      end
      if (has_owed[RANK_W'(idx)]) begin
        if (!any_cand) begin
          any_cand = 1'b1;
          any_win  = RANK_W'(idx);
        end
        if (urgent[RANK_W'(idx)] && !urg_found) begin
          urg_found = 1'b1;
          urg_win   = RANK_W'(idx);
        end
      end
    end
    winner = urg_found ? urg_win : any_win;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_ARB;
      ref_rank   <= '0;
      ptr        <= '0;
      ref_urgent <= 1'b0;
    end else begin
      state      <= state_next;
      ref_rank   <= rank_next;
      ptr        <= ptr_next;
      ref_urgent <= urgent_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ARB:  if (any_cand)   state_next = ST_REQ;
      ST_REQ:  if (cmd_issued) state_next = ST_ARB;
      default: state_next = ST_ARB;
    endcase
  end

  // Rank is locked while requesting; urgency follows the locked rank's next owed value.
  always_comb begin
    rank_next   = ref_rank;
    ptr_next    = ptr;
    urgent_next = 1'b0;
    if (state == ST_ARB && any_cand) begin
      rank_next = winner;
    end
    if (handshake) begin
      ptr_next = (ref_rank == RANK_W'(NUM_RANKS - 1)) ? '0 : ref_rank + RANK_W'(1);
    end
    urgent_next = (state_next == ST_REQ) && urgent_nxt[rank_next];
  end

endmodule
